alu_exec_unit: RTL and testbench

- Execute-stage ALU fed directly by the arithmetic controller's 4-bit op code.
- Single-cycle ops complete with 1-cycle latency.
- Shifts run 1 bit/cycle; mul and div run iteratively for WIDTH cycles.
- Valid/ready handshake on both sides lets the pipeline stall while a long op is busy.

---
 rtl/alu_exec_unit.sv | 185 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, bit-serial shifts, iterative
// shift-add multiply and restoring unsigned divide behind a valid/ready handshake.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             equal,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_SLL  = 4'h0;
  localparam logic [3:0] OP_SRA  = 4'h1;
  localparam logic [3:0] OP_SRL  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIVU = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NOR  = 4'hA;
  localparam logic [3:0] OP_SLT  = 4'hB;
  localparam logic [3:0] OP_SLTU = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;     // shift work / product / quotient
  logic [WIDTH-1:0] y_q, y_d;     // multiplicand / divisor
  logic [WIDTH-1:0] z_q, z_d;     // multiplier
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             eq_q, eq_d;

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] iter_x;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_sub;
  logic             q_bit;

  assign shamt = b[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // Restoring divide step; a zero divisor always "fits", giving an all-ones quotient.
  assign r_sh  = {rem_q, x_q[WIDTH-1]};
  assign q_bit = (r_sh >= {1'b0, y_q});
  assign r_sub = r_sh[WIDTH-1:0] - y_q;

  always_comb begin
    iter_x = x_q;
    case (op_q)
      OP_SLL:  iter_x = x_q << 1;
      OP_SRA:  iter_x = {x_q[WIDTH-1], x_q[WIDTH-1:1]};
      OP_SRL:  iter_x = {1'b0, x_q[WIDTH-1:1]};
      OP_MUL:  iter_x = x_q + (z_q[0] ? y_q : '0);
      OP_DIVU: iter_x = {x_q[WIDTH-2:0], q_bit};
      default: iter_x = x_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    rem_d   = rem_q;
    res_d   = res_q;
    eq_d    = eq_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = op;
          eq_d = (a == b);
          case (op)
            OP_SLL, OP_SRA, OP_SRL: begin
              if (shamt == '0) begin
                res_d   = a;
                state_d = S_DONE;
              end else begin
                x_d     = a;
                cnt_d   = {1'b0, shamt};
                state_d = S_BUSY;
              end
            end
            OP_MUL: begin
              x_d     = '0;
              y_d     = a;
              z_d     = b;
              cnt_d   = CW'(WIDTH);
              state_d = S_BUSY;
            end
            OP_DIVU: begin
              x_d     = a;
              y_d     = b;
              rem_d   = '0;
              cnt_d   = CW'(WIDTH);
              state_d = S_BUSY;
            end
            default: begin
              res_d   = alu_res;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_BUSY: begin
        x_d   = iter_x;
        y_d   = (op_q == OP_MUL) ? (y_q << 1) : y_q;
        z_d   = z_q >> 1;
        rem_d = q_bit ? r_sub : r_sh[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = iter_x;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      eq_q    <= eq_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign equal     = eq_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed table plus hand-written reset/backpressure/back-to-back sequences
// for alu_exec_unit.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, equal, busy;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .equal(equal), .busy(busy)
  );

  always @(posedge clk)
    if (!rst && in_ready)
      assert (!$isunknown({in_valid, op})) else $error("in_valid/op unknown while in_ready");

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string        nm;
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic         eq;
    int           lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y,
                              logic [W-1:0] r, logic e, int l);
    vec_t v;
    v.nm = nm; v.op = o; v.a = x; v.b = y; v.res = r; v.eq = e; v.lat = l;
    return v;
  endfunction

  function automatic logic [W-1:0] model(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y);
    logic [4:0] sh;
    sh = y[4:0];
    case (o)
      4'h0: model = x << sh;
      4'h1: model = $signed(x) >>> sh;
      4'h2: model = x >> sh;
      4'h3: model = x * y;
      4'h4: model = (y == '0) ? '1 : x / y;
      4'h5: model = x + y;
      4'h6: model = x - y;
      4'h7: model = x & y;
      4'h8: model = x | y;
      4'h9: model = x ^ y;
      4'hA: model = ~(x | y);
      4'hB: model = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'hC: model = (x < y) ? 32'd1 : 32'd0;
      default: model = '0;
    endcase
  endfunction

  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clk);
    lat = 0;
    while (!in_ready && lat < 100) begin @(negedge clk); lat++; end
    chk({v.nm, " in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    chk({v.nm, " latency"}, W'(lat), W'(v.lat));
    chk({v.nm, " result"}, result, v.res);
    chk({v.nm, " equal"}, W'(equal), W'(v.eq));
  endtask

  logic [W-1:0] expq[$];
  logic         eqq[$];

  initial begin
    int cnt;
    tbl.push_back(mk("add wrap", 4'h5, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1));
    tbl.push_back(mk("sub eq",   4'h6, 32'h5, 32'h5, 32'h0, 1'b1, 1));
    tbl.push_back(mk("sub wrap", 4'h6, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1));
    tbl.push_back(mk("slt neg",  4'hB, 32'h8000_0000, 32'h1, 32'h1, 1'b0, 1));
    tbl.push_back(mk("sltu big", 4'hC, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 1));
    tbl.push_back(mk("slt pos",  4'hB, 32'h1, 32'h8000_0000, 32'h0, 1'b0, 1));
    tbl.push_back(mk("sltu sml", 4'hC, 32'h1, 32'h8000_0000, 32'h1, 1'b0, 1));
    tbl.push_back(mk("and",      4'h7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1));
    tbl.push_back(mk("or",       4'h8, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1));
    tbl.push_back(mk("nor",      4'hA, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1));
    tbl.push_back(mk("unassign", 4'hE, 32'h7, 32'h7, 32'h0, 1'b1, 1));
    tbl.push_back(mk("sra 4",    4'h1, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 5));
    tbl.push_back(mk("srl 4",    4'h2, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 5));
    tbl.push_back(mk("sll 5",    4'h0, 32'h1, 32'h25, 32'h20, 1'b0, 6));
    tbl.push_back(mk("sra 0",    4'h1, 32'hABCD, 32'h0, 32'hABCD, 1'b0, 1));
    tbl.push_back(mk("sll b20",  4'h0, 32'h1234, 32'h20, 32'h1234, 1'b0, 1));
    tbl.push_back(mk("sra 31",   4'h1, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0, 32));
    tbl.push_back(mk("mul",      4'h3, 32'h12345, 32'h1000, 32'h1234_5000, 1'b0, 33));
    tbl.push_back(mk("mul ones", 4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b1, 33));
    tbl.push_back(mk("divu",     4'h4, 32'd100, 32'd7, 32'd14, 1'b0, 33));
    tbl.push_back(mk("divu /0",  4'h4, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0, 33));
    tbl.push_back(mk("divu sml", 4'h4, 32'd7, 32'd100, 32'd0, 1'b0, 33));

    // reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready",  W'(in_ready), W'(1));
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst result",    result, '0);
    chk("rst equal",     W'(equal), W'(0));
    chk("rst busy",      W'(busy), W'(0));

    foreach (tbl[i]) run_op(tbl[i]);

    // backpressure
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'h9; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp out_valid", W'(out_valid), W'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold result", result, 32'h0FF0_0FF0);
      chk("bp hold valid",  W'(out_valid), W'(1));
      chk("bp in_ready",    W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release in_ready",  W'(in_ready), W'(1));
    chk("bp release out_valid", W'(out_valid), W'(0));

    // reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; op = 4'h3; a = 32'd3; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mul busy", W'(busy), W'(1));
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid rst out_valid", W'(out_valid), W'(0));
    chk("mid rst busy",      W'(busy), W'(0));
    chk("mid rst in_ready",  W'(in_ready), W'(1));
    chk("mid rst result",    result, '0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no stale out_valid", W'(cnt), W'(0));
    run_op(mk("add post-rst", 4'h5, 32'd2, 32'd3, 32'd5, 1'b0, 1));

    // back-to-back with in_valid held high
    fork
      begin : drv
        int w;
        logic [3:0] ro;
        logic [W-1:0] ra, rb;
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
          ro = 4'($urandom_range(0, 15));
          ra = $urandom;
          rb = (i % 4 == 0) ? ra : $urandom;
          op = ro; a = ra; b = rb;
          w = 0;
          while (!in_ready && w < 500) begin @(negedge clk); w++; end
          if (w >= 500) begin
            n_chk++; n_fail++;
            $display("FAIL b2b accept timeout: op %0d not accepted", i);
          end
          expq.push_back(model(ro, ra, rb));
          eqq.push_back(ra == rb);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin : mon
        int cyc, got;
        logic r, e;
        logic [W-1:0] x;
        cyc = 0; got = 0;
        while (got < 20 && cyc < 4000) begin
          @(negedge clk);
          cyc++;
          r = ($urandom_range(0, 3) != 0);
          out_ready = r;
          if (out_valid && r) begin
            if (expq.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL b2b extra result: got %h, want none", result);
            end else begin
              x = expq.pop_front();
              e = eqq.pop_front();
              chk("b2b result", result, x);
              chk("b2b equal", W'(equal), W'(e));
            end
            got++;
          end
        end
        chk("b2b result count", W'(got), W'(20));
        out_ready = 1'b1;
      end
    join
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("b2b no duplicates", W'(cnt), W'(0));
    chk("b2b queue drained", W'(expq.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
